pp_tree_accum: RTL and testbench

Parametrised, fully pipelined signed partial-product adder tree with an optional saturating accumulator. It is the successor to the fixed 9-input single-register summing stage. It sits after partial-product alignment in the SD4 MAC datapath and reduces `NUM_PP` aligned partial products to one sum per cycle. The sum can either pass straight through or be accumulated across vectors for dot-product use.

---
 rtl/pp_tree_accum.sv | 114 +++++++++++
 tb/tb_pp_tree_accum.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pp_tree_accum.sv
// pp_tree_accum: pipelined signed partial-product adder tree with optional saturating accumulator
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   ce             : global enable, 0 freezes every register
//   in_valid, in_first, acc_mode, pp_in[NUM_PP*PP_W] : input vector and its sideband
//   out_valid, sum_out[ACC_W], sat : result L+1 enabled cycles later, sticky saturation flag
module pp_tree_accum #(
    parameter int NUM_PP = 9,
    parameter int PP_W   = 16,
    parameter int ACC_W  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   acc_mode,
    input  logic [NUM_PP*PP_W-1:0] pp_in,
    output logic                   out_valid,
    output logic [ACC_W-1:0]       sum_out,
    output logic                   sat
);
    localparam int L  = $clog2(NUM_PP);
    localparam int TW = PP_W + L;

    function automatic int nodes(input int k);
        int n = NUM_PP;
        for (int j = 0; j < k; j++) n = (n + 1) / 2;
        return n;
    endfunction

    genvar k, i;
    for (k = 0; k <= L; k++) begin : lv
        localparam int N = nodes(k);
        localparam int W = PP_W + k;
        logic [N-1:0][W-1:0] node;
        if (k == 0) begin : g_in
            assign node = pp_in;
        end else begin : g_add
            localparam int NP = nodes(k - 1);
            for (i = 0; i < N; i++) begin : n
                logic [W-1:0] sum;
                logic [W-1:0] r;
                // one-bit sign extension of each operand keeps every add overflow-free
                if (2 * i + 1 < NP) begin : g_pair
                    assign sum = {lv[k-1].node[2*i][W-2], lv[k-1].node[2*i]}
                               + {lv[k-1].node[2*i+1][W-2], lv[k-1].node[2*i+1]};
                end else begin : g_pass
                    assign sum = {lv[k-1].node[2*i][W-2], lv[k-1].node[2*i]};
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r <= '0;
                    else if (ce) r <= sum;
                end
                assign node[i] = r;
            end
        end
    end

    logic [L-1:0] v_pipe, f_pipe, m_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe <= '0;
            f_pipe <= '0;
            m_pipe <= '0;
        end else if (ce) begin
            v_pipe[0] <= in_valid;
            f_pipe[0] <= in_first;
            m_pipe[0] <= acc_mode;
            for (int j = 1; j < L; j++) begin
                v_pipe[j] <= v_pipe[j-1];
                f_pipe[j] <= f_pipe[j-1];
                m_pipe[j] <= m_pipe[j-1];
            end
        end
    end

    logic [TW-1:0]    root;
    logic [ACC_W:0]   t, r;
    logic [ACC_W-1:0] acc, clamped;
    logic             ovf;

    assign root = lv[L].node[0];
    assign t    = {{(ACC_W + 1 - TW){root[TW-1]}}, root};
    assign r    = {acc[ACC_W-1], acc} + t;
    // r[ACC_W] is the true sign; disagreement with r[ACC_W-1] means out of ACC_W range
    assign ovf  = r[ACC_W] ^ r[ACC_W-1];

    always_comb clamped = ovf ? {r[ACC_W], {(ACC_W-1){~r[ACC_W]}}} : r[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sum_out   <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= v_pipe[L-1];
            if (v_pipe[L-1]) begin
                if (!m_pipe[L-1]) begin
                    sum_out <= t[ACC_W-1:0];
                end else if (f_pipe[L-1]) begin
                    acc     <= t[ACC_W-1:0];
                    sum_out <= t[ACC_W-1:0];
                    sat     <= 1'b0;
                end else begin
                    acc     <= clamped;
                    sum_out <= clamped;
                    sat     <= sat | ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_pp_tree_accum.sv
// tb_pp_tree_accum: directed-vector bench with per-cycle behavioural model and literal spot checks
module tb_pp_tree_accum;
    localparam int NUM_PP = 9;
    localparam int PP_W   = 16;
    localparam int ACC_W  = 24;
    localparam int L      = $clog2(NUM_PP);
    localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W - 1));

    typedef struct { int due; logic [ACC_W-1:0] s; logic sat; } exp_t;
    typedef struct { int cyc; int s; logic sat; } rec_t;

    logic clk = 0, rst = 1, ce = 1, in_valid = 0, in_first = 0, acc_mode = 0;
    logic [NUM_PP*PP_W-1:0] pp_in = '0;
    logic out_valid, sat;
    logic [ACC_W-1:0] sum_out;

    int errors = 0, checks = 0, cyc = 0, n = 0;
    exp_t q[$];
    rec_t outs[$];
    longint m_acc = 0, s, r;
    logic m_sat = 0, adv = 0, e_v = 0, e_sat = 0;
    logic [ACC_W-1:0] e_sum = '0;

    pp_tree_accum #(.NUM_PP(NUM_PP), .PP_W(PP_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .acc_mode(acc_mode), .pp_in(pp_in), .out_valid(out_valid), .sum_out(sum_out), .sat(sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // behavioural model: results computed from the arithmetic rules, released after L+1 enabled edges
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_acc = 0; m_sat = 0; n = 0; adv = 0;
            e_v = 0; e_sum = '0; e_sat = 0;
        end else begin
            adv = ce;
            if (ce) begin
                n++;
                e_v = 0;
                if (q.size() != 0 && q[0].due == n) begin
                    e_v = 1; e_sum = q[0].s; e_sat = q[0].sat;
                    void'(q.pop_front());
                end
                if (in_valid) begin
                    s = 0;
                    for (int j = 0; j < NUM_PP; j++) s += longint'($signed(pp_in[j*PP_W +: PP_W]));
                    r = s;
                    if (acc_mode && in_first) begin
                        m_acc = s; m_sat = 0;
                    end else if (acc_mode) begin
                        r = m_acc + s;
                        if (r > MAXV) begin r = MAXV; m_sat = 1; end
                        else if (r < MINV) begin r = MINV; m_sat = 1; end
                        m_acc = r;
                    end
                    q.push_back('{n + L, ACC_W'(r), m_sat});
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (out_valid !== e_v || sum_out !== e_sum || sat !== e_sat) begin
            errors++;
            $display("FAIL model @%0d: dut v=%b sum=%0d sat=%b, model v=%b sum=%0d sat=%b",
                     cyc, out_valid, $signed(sum_out), sat, e_v, $signed(e_sum), e_sat);
        end
        if (out_valid && adv) outs.push_back('{cyc, int'($signed(sum_out)), sat});
    end

    task automatic lit(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int idx, input int c, input int sv, input logic st);
        if (idx >= outs.size()) lit({nm, " present"}, outs.size(), idx + 1);
        else begin
            lit({nm, " cycle"}, outs[idx].cyc, c);
            lit({nm, " sum"}, outs[idx].s, sv);
            lit({nm, " sat"}, outs[idx].sat, st);
        end
    endtask

    task automatic put(input logic v, input logic f, input logic m, input int val);
        in_valid = v; in_first = f; acc_mode = m;
        for (int j = 0; j < NUM_PP; j++) pp_in[j*PP_W +: PP_W] = PP_W'(val);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        in_valid = 0; in_first = 0; acc_mode = 0;
        repeat (k) @(negedge clk);
    endtask

    int t0;

    initial begin
        repeat (2) @(negedge clk);
        lit("reset out_valid", out_valid, 0);
        lit("reset sum_out", sum_out, 0);
        lit("reset sat", sat, 0);
        rst = 0;
        @(negedge clk);

        outs.delete(); t0 = cyc;
        put(1, 0, 0, 1);
        idle(8);
        lit("ones count", outs.size(), 1);
        chk_out("ones", 0, t0 + 5, 9, 0);

        outs.delete(); t0 = cyc;
        put(1, 0, 0, -32768);
        put(1, 0, 0, 32767);
        idle(7);
        chk_out("min", 0, t0 + 5, -294912, 0);
        chk_out("max", 1, t0 + 6, 294903, 0);

        outs.delete(); t0 = cyc;
        for (int j = 0; j < 5; j++) put(1, j == 0, 1, 100);
        idle(8);
        lit("acc100 count", outs.size(), 5);
        for (int j = 0; j < 5; j++) chk_out($sformatf("acc100[%0d]", j), j, t0 + 5 + j, 900 * (j + 1), 0);

        outs.delete(); t0 = cyc;
        for (int j = 0; j < 29; j++) put(1, j == 0, 1, 32767);
        put(1, 1, 1, 1);
        idle(8);
        lit("satrun count", outs.size(), 30);
        chk_out("satrun first", 0, t0 + 5, 294903, 0);
        chk_out("satrun 28", 27, t0 + 32, 8257284, 0);
        chk_out("satrun clamp", 28, t0 + 33, 8388607, 1);
        chk_out("satrun restart", 29, t0 + 34, 9, 0);

        outs.delete(); t0 = cyc;
        put(1, 0, 0, 1);
        put(1, 0, 0, 2);
        ce = 0;
        idle(3);
        ce = 1;
        idle(8);
        lit("stall count", outs.size(), 2);
        chk_out("stall a", 0, t0 + 8, 9, 0);
        chk_out("stall b", 1, t0 + 9, 18, 0);

        outs.delete(); t0 = cyc;
        put(1, 0, 0, 3);
        put(1, 0, 0, 4);
        idle(1);
        #2 rst = 1;
        #1;
        lit("async rst out_valid", out_valid, 0);
        lit("async rst sum_out", sum_out, 0);
        lit("async rst sat", sat, 0);
        @(negedge clk);
        rst = 0;
        while (cyc < t0 + 6) @(negedge clk);
        put(1, 0, 0, 5);
        idle(8);
        lit("post-rst count", outs.size(), 1);
        chk_out("post-rst", 0, t0 + 11, 45, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
